x_calc_scheduler: RTL and testbench
===================================

X_CALC_SCHEDULER -- requirements
Module: x_calc_scheduler

Interface
REQ-001 SHALL have parameter N, default 16: sample width, signed Q8.8.
REQ-002 SHALL have parameter NUM_Q, default 16: number of q iterations per run.
REQ-003 SHALL have parameter TIMEOUT, default 256: maximum WAIT_DONE cycles before abort.
REQ-004 SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  write target: 0 = H buffer (16 entries), 1 = Y buffer (8 entries).
- wr_addr  in  4  buffer address; for Y, bit 3 is ignored.
- wr_r, wr_i  in  N  write data, real and imaginary.
- run  in  1  start-of-run pulse.
- q_done  in  1  completion from x_calculate.
- xI1_in, xQ1_in, xI2_in, xQ2_in  in  16 each  detector results.
- res_ready  in  1  result consumer ready.
- start_new_q  out  1  one-cycle pulse to x_calculate.
- q_index  out  4  current q.
- H_in_valid  out  1  H stream valid.
- H_in_r, H_in_i  out  N  H stream data.
- Y_in_valid  out  1  Y stream valid.
- Y_in_r, Y_in_i  out  N  Y stream data.
- res_valid  out  1  result valid.
- res_q  out  4  q of the held result.
- res_xI1, res_xQ1, res_xI2, res_xQ2  out  16 each  captured results.
- busy  out  1  high in any state except IDLE.
- all_done  out  1  one-cycle pulse when a run ends.
- timeout_err  out  1  sticky timeout flag.

Function
REQ-005 SHALL register all outputs; stream data SHALL be read from internal buffers with registered output.
REQ-006 SHALL implement states IDLE, START, STREAM, WAIT_DONE, OUT and FIN.
REQ-007 In IDLE, wr_en SHALL write wr_r/wr_i into the selected buffer at wr_addr; wr_en outside IDLE SHALL be ignored.
REQ-008 run in IDLE SHALL clear q to 0, clear timeout_err and go to START; run in any other state SHALL be ignored.
REQ-009 START (one cycle) SHALL drive start_new_q=1 with q_index=q, then go to STREAM.
REQ-010 STREAM SHALL last exactly 16 cycles, cnt 0..15:
- H_in_valid=1 with H[cnt] on every cycle.
- Y_in_valid=1 with Y[cnt] only while cnt<8.
- First valid beat SHALL be the cycle immediately after the start_new_q cycle.
REQ-011 After cnt=15, STREAM SHALL go to WAIT_DONE with all valids low and data held at the last value.
REQ-012 In WAIT_DONE, q_done=1 SHALL capture x*_in into res_x*, set res_q=q, and go to OUT; the wait counter SHALL reset on WAIT_DONE entry.
REQ-013 q_done asserted outside WAIT_DONE SHALL be ignored.
REQ-014 If the wait counter reaches TIMEOUT-1 without q_done, the block SHALL set timeout_err=1 and go to IDLE without asserting all_done.
REQ-015 OUT SHALL hold res_valid=1 with stable res_* until res_ready=1; the transfer occurs on the cycle where res_valid and res_ready are both high.
REQ-016 On transfer: if q=NUM_Q-1, go to FIN; otherwise q increments and the block goes to START.
REQ-017 FIN SHALL pulse all_done for one cycle, then go to IDLE.
REQ-018 Minimum per-q latency SHALL be 1 (START) + 16 (STREAM) + WAIT_DONE cycles + 1 (OUT with res_ready held high).

Reset
REQ-019 While rst=0, the block SHALL be in IDLE, with q=0, cnt=0, and every output 0 (including timeout_err and res_*).
REQ-020 Buffer contents SHALL NOT be reset.
REQ-021 Reset asserted mid-run SHALL abort immediately, with no all_done pulse.

Verification
REQ-022 Sequential data run:
- Stimulus: write H[k]=k<<8 and Y[k]=(k+1)<<8, pulse run, model q_done 5 cycles after the last H beat, hold res_ready=1.
- Required: 16 start_new_q pulses with q_index 0..15; each followed by 16 H beats (0x0000..0x0F00) and 8 Y beats (0x0100..0x0800); 16 results with res_q 0..15; one all_done.
REQ-023 Backpressure:
- Stimulus: hold res_ready=0 for 10 cycles in OUT.
- Required: res_valid stays high, res_* stable, no new start_new_q until the transfer.
REQ-024 Timeout:
- Stimulus: TIMEOUT=256 and no q_done at q=3.
- Required: timeout_err=1 after 256 WAIT_DONE cycles, return to IDLE, busy=0, no all_done.
REQ-025 Spurious inputs:
- Stimulus: q_done during STREAM, run during WAIT_DONE, wr_en during STREAM.
- Required: all ignored; buffers unchanged; sequence unaffected.
REQ-026 Reset during STREAM:
- Stimulus: rst=0 at cnt=7.
- Required: all outputs 0 immediately; after release, a new run restarts at q_index=0 with buffer contents intact.

Source files
------------

// File: rtl/x_calc_scheduler.sv
// x_calc_scheduler: sequences NUM_Q runs of the x_calculate engine.
// For each q it pulses start_new_q, streams the 16-entry H buffer and the
// 8-entry Y buffer, waits for q_done (bounded by TIMEOUT), then presents the
// detector results on a valid/ready port. Buffers are loaded only while idle.
module x_calc_scheduler #(
    parameter int unsigned N       = 16,
    parameter int unsigned NUM_Q   = 16,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rst,

    // Buffer load port
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [3:0]   wr_addr,
    input  logic [N-1:0] wr_r,
    input  logic [N-1:0] wr_i,

    // Run control and engine handshake
    input  logic         run,
    input  logic         q_done,
    input  logic [15:0]  xI1_in,
    input  logic [15:0]  xQ1_in,
    input  logic [15:0]  xI2_in,
    input  logic [15:0]  xQ2_in,
    input  logic         res_ready,

    output logic         start_new_q,
    output logic [3:0]   q_index,

    // Sample streams towards x_calculate
    output logic         H_in_valid,
    output logic [N-1:0] H_in_r,
    output logic [N-1:0] H_in_i,
    output logic         Y_in_valid,
    output logic [N-1:0] Y_in_r,
    output logic [N-1:0] Y_in_i,

    // Result port
    output logic         res_valid,
    output logic [3:0]   res_q,
    output logic [15:0]  res_xI1,
    output logic [15:0]  res_xQ1,
    output logic [15:0]  res_xI2,
    output logic [15:0]  res_xQ2,

    // Status
    output logic         busy,
    output logic         all_done,
    output logic         timeout_err
);

    // Wait counter is wide enough to reach TIMEOUT-1.
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [3:0]    Q_LAST    = 4'(NUM_Q - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StStream,
        StWaitDone,
        StOut,
        StFin
    } state_t;

    state_t          state;
    logic [3:0]      q;
    logic [3:0]      cnt;
    logic [WW-1:0]   wait_cnt;
    logic [3:0]      cnt_nxt;

    // Sample buffers; deliberately not reset so contents survive a reset.
    logic [N-1:0]    h_r_mem [16];
    logic [N-1:0]    h_i_mem [16];
    logic [N-1:0]    y_r_mem [8];
    logic [N-1:0]    y_i_mem [8];

    assign cnt_nxt = cnt + 4'd1;

    // Buffer writes are accepted only while idle; Y ignores address bit 3.
    always_ff @(posedge clk) begin
        if (wr_en && (state == StIdle)) begin
            if (!wr_sel) begin
                h_r_mem[wr_addr] <= wr_r;
                h_i_mem[wr_addr] <= wr_i;
            end else begin
                y_r_mem[wr_addr[2:0]] <= wr_r;
                y_i_mem[wr_addr[2:0]] <= wr_i;
            end
        end
    end

    // Scheduler FSM with every output registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            q           <= 4'd0;
            cnt         <= 4'd0;
            wait_cnt    <= '0;
            start_new_q <= 1'b0;
            q_index     <= 4'd0;
            H_in_valid  <= 1'b0;
            H_in_r      <= '0;
            H_in_i      <= '0;
            Y_in_valid  <= 1'b0;
            Y_in_r      <= '0;
            Y_in_i      <= '0;
            res_valid   <= 1'b0;
            res_q       <= 4'd0;
            res_xI1     <= 16'd0;
            res_xQ1     <= 16'd0;
            res_xI2     <= 16'd0;
            res_xQ2     <= 16'd0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            start_new_q <= 1'b0;
            all_done    <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (run) begin
                        state       <= StStart;
                        q           <= 4'd0;
                        q_index     <= 4'd0;
                        timeout_err <= 1'b0;
                        start_new_q <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                // First beat lands in the cycle right after start_new_q.
                StStart: begin
                    state      <= StStream;
                    cnt        <= 4'd0;
                    H_in_valid <= 1'b1;
                    H_in_r     <= h_r_mem[0];
                    H_in_i     <= h_i_mem[0];
                    Y_in_valid <= 1'b1;
                    Y_in_r     <= y_r_mem[0];
                    Y_in_i     <= y_i_mem[0];
                end

                // Y drops out after eight beats; its data holds at Y[7].
                StStream: begin
                    if (cnt == 4'd15) begin
                        state      <= StWaitDone;
                        H_in_valid <= 1'b0;
                        Y_in_valid <= 1'b0;
                        wait_cnt   <= '0;
                    end else begin
                        cnt    <= cnt_nxt;
                        H_in_r <= h_r_mem[cnt_nxt];
                        H_in_i <= h_i_mem[cnt_nxt];
                        if (!cnt_nxt[3]) begin
                            Y_in_r <= y_r_mem[cnt_nxt[2:0]];
                            Y_in_i <= y_i_mem[cnt_nxt[2:0]];
                        end else begin
                            Y_in_valid <= 1'b0;
                        end
                    end
                end

                // q_done wins over the timeout on the final wait cycle.
                StWaitDone: begin
                    if (q_done) begin
                        state     <= StOut;
                        res_valid <= 1'b1;
                        res_q     <= q;
                        res_xI1   <= xI1_in;
                        res_xQ1   <= xQ1_in;
                        res_xI2   <= xI2_in;
                        res_xQ2   <= xQ2_in;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= StIdle;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // Result held until the consumer takes it.
                StOut: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (q == Q_LAST) begin
                            state    <= StFin;
                            all_done <= 1'b1;
                        end else begin
                            state       <= StStart;
                            q           <= q + 4'd1;
                            q_index     <= q + 4'd1;
                            start_new_q <= 1'b1;
                        end
                    end
                end

                StFin: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_calc_scheduler.sv
// Bench for x_calc_scheduler: a cycle-offset reference model derived from the
// run timeline (start, 16 H beats, 8 Y beats, wait, result handshake), plus a
// table of per-q wait/backpressure settings with hand-computed q periods.
module tb_x_calc_scheduler;

    localparam int N       = 16;
    localparam int NUM_Q   = 16;
    localparam int TIMEOUT = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic         wr_sel = 1'b0;
    logic [3:0]   wr_addr = 4'd0;
    logic [N-1:0] wr_r = '0;
    logic [N-1:0] wr_i = '0;
    logic         run = 1'b0;
    logic         q_done = 1'b0;
    logic [15:0]  xI1_in = 16'd0;
    logic [15:0]  xQ1_in = 16'd0;
    logic [15:0]  xI2_in = 16'd0;
    logic [15:0]  xQ2_in = 16'd0;
    logic         res_ready = 1'b0;

    logic         start_new_q;
    logic [3:0]   q_index;
    logic         H_in_valid;
    logic [N-1:0] H_in_r;
    logic [N-1:0] H_in_i;
    logic         Y_in_valid;
    logic [N-1:0] Y_in_r;
    logic [N-1:0] Y_in_i;
    logic         res_valid;
    logic [3:0]   res_q;
    logic [15:0]  res_xI1;
    logic [15:0]  res_xQ1;
    logic [15:0]  res_xI2;
    logic [15:0]  res_xQ2;
    logic         busy;
    logic         all_done;
    logic         timeout_err;

    x_calc_scheduler #(
        .N       (N),
        .NUM_Q   (NUM_Q),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_r        (wr_r),
        .wr_i        (wr_i),
        .run         (run),
        .q_done      (q_done),
        .xI1_in      (xI1_in),
        .xQ1_in      (xQ1_in),
        .xI2_in      (xI2_in),
        .xQ2_in      (xQ2_in),
        .res_ready   (res_ready),
        .start_new_q (start_new_q),
        .q_index     (q_index),
        .H_in_valid  (H_in_valid),
        .H_in_r      (H_in_r),
        .H_in_i      (H_in_i),
        .Y_in_valid  (Y_in_valid),
        .Y_in_r      (Y_in_r),
        .Y_in_i      (Y_in_i),
        .res_valid   (res_valid),
        .res_q       (res_q),
        .res_xI1     (res_xI1),
        .res_xQ1     (res_xQ1),
        .res_xI2     (res_xI2),
        .res_xQ2     (res_xQ2),
        .busy        (busy),
        .all_done    (all_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    // Model copy of the buffers, updated only by writes made while idle.
    logic [N-1:0] h_r [16];
    logic [N-1:0] h_i [16];
    logic [N-1:0] y_r [8];
    logic [N-1:0] y_i [8];

    int starts[$];

    // d: cycles from last H beat to q_done; r: cycles res_ready held low in OUT;
    // period: start_new_q to next start_new_q = 1 + 16 + d + (r + 1).
    typedef struct {
        int d;
        int r;
        int period;
    } vec_t;
    vec_t tbl[4];

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".start_new_q"}, 32'(start_new_q), 0);
        chk({tag, ".q_index"},     32'(q_index), 0);
        chk({tag, ".H_in_valid"},  32'(H_in_valid), 0);
        chk({tag, ".H_in_r"},      32'(H_in_r), 0);
        chk({tag, ".H_in_i"},      32'(H_in_i), 0);
        chk({tag, ".Y_in_valid"},  32'(Y_in_valid), 0);
        chk({tag, ".Y_in_r"},      32'(Y_in_r), 0);
        chk({tag, ".Y_in_i"},      32'(Y_in_i), 0);
        chk({tag, ".res_valid"},   32'(res_valid), 0);
        chk({tag, ".res_q"},       32'(res_q), 0);
        chk({tag, ".res_xI1"},     32'(res_xI1), 0);
        chk({tag, ".res_xQ1"},     32'(res_xQ1), 0);
        chk({tag, ".res_xI2"},     32'(res_xI2), 0);
        chk({tag, ".res_xQ2"},     32'(res_xQ2), 0);
        chk({tag, ".busy"},        32'(busy), 0);
        chk({tag, ".all_done"},    32'(all_done), 0);
        chk({tag, ".timeout_err"}, 32'(timeout_err), 0);
    endtask

    // Call only while the block is idle.
    task automatic wr_buf(input bit sel, input logic [3:0] addr, input logic [N-1:0] r,
                          input logic [N-1:0] i);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_r = r; wr_i = i;
        step();
        wr_en = 1'b0;
        if (!sel) begin
            h_r[addr] = r; h_i[addr] = i;
        end else begin
            y_r[addr[2:0]] = r; y_i[addr[2:0]] = i;
        end
    endtask

    task automatic load_seq();
        for (int k = 0; k < 16; k++) wr_buf(1'b0, 4'(k), N'(k << 8), N'((16 - k) << 8));
        // Odd Y addresses carry bit 3 set, which must be ignored.
        for (int k = 0; k < 8; k++)
            wr_buf(1'b1, 4'(k + ((k % 2 == 1) ? 8 : 0)), N'((k + 1) << 8), N'(k * 3 + 1));
    endtask

    task automatic load_rand();
        for (int k = 0; k < 16; k++) wr_buf(1'b0, 4'(k), N'($urandom), N'($urandom));
        for (int k = 0; k < 8; k++) wr_buf(1'b1, 4'($urandom_range(0, 1) * 8 + k), N'($urandom),
                                            N'($urandom));
    endtask

    task automatic pick(input int mode, input int q, output int d, output int r);
        case (mode)
            0:       begin d = 5; r = 0; end
            1:       begin d = tbl[q % 4].d; r = tbl[q % 4].r; end
            default: begin
                d = $urandom_range(1, 8);
                r = (q == 2) ? 10 : $urandom_range(0, 3);
            end
        endcase
    endtask

    // One full run. Expectations come from o = cycles since the model's start
    // of the current q. to_q >= 0 withholds q_done at that q (timeout case).
    task automatic do_run(input int mode, input int to_q, input bit spur);
        int s_cyc, o, q_m, d, r, guard;
        logic [15:0] e1, e2, e3, e4;
        bit fin, e_hv, e_yv, e_rv, e_ad, e_busy, e_te;
        starts.delete();
        e1 = 0; e2 = 0; e3 = 0; e4 = 0;
        step();
        chk("idle_busy", 32'(busy), 0);
        run = 1'b1;
        s_cyc = cyc + 1;
        q_m = 0;
        pick(mode, 0, d, r);
        if (to_q == 0) d = -1;
        fin = 0;
        guard = 0;
        while (!fin) begin
            step();
            run = 1'b0; q_done = 1'b0; wr_en = 1'b0;
            guard++;
            o = cyc - s_cyc;
            if (d >= 0 && o == 18 + d + r && q_m < NUM_Q - 1) begin
                q_m++;
                s_cyc = cyc;
                o = 0;
                pick(mode, q_m, d, r);
                if (q_m == to_q) d = -1;
            end
            if (start_new_q) starts.push_back(cyc);

            e_hv = (o >= 1 && o <= 16);
            e_yv = (o >= 1 && o <= 8);
            if (d < 0) begin
                e_rv = 0; e_ad = 0;
                e_busy = (o < 17 + TIMEOUT);
                e_te = !e_busy;
            end else begin
                e_rv = (o >= 17 + d && o <= 17 + d + r);
                e_ad = (q_m == NUM_Q - 1 && o == 18 + d + r);
                e_busy = !(q_m == NUM_Q - 1 && o >= 19 + d + r);
                e_te = 0;
            end
            if (!e_busy) fin = 1;

            chk("start_new_q", 32'(start_new_q), 32'(o == 0));
            chk("q_index", 32'(q_index), 32'(q_m));
            chk("H_in_valid", 32'(H_in_valid), 32'(e_hv));
            chk("Y_in_valid", 32'(Y_in_valid), 32'(e_yv));
            if (e_hv) begin
                chk("H_in_r", 32'(H_in_r), 32'(h_r[o - 1]));
                chk("H_in_i", 32'(H_in_i), 32'(h_i[o - 1]));
            end else if (o > 16) begin
                chk("H_hold", 32'(H_in_r), 32'(h_r[15]));
            end
            if (e_yv) begin
                chk("Y_in_r", 32'(Y_in_r), 32'(y_r[o - 1]));
                chk("Y_in_i", 32'(Y_in_i), 32'(y_i[o - 1]));
            end else if (o > 8) begin
                chk("Y_hold", 32'(Y_in_r), 32'(y_r[7]));
            end
            chk("res_valid", 32'(res_valid), 32'(e_rv));
            if (e_rv) begin
                chk("res_q", 32'(res_q), 32'(q_m));
                chk("res_xI1", 32'(res_xI1), 32'(e1));
                chk("res_xQ1", 32'(res_xQ1), 32'(e2));
                chk("res_xI2", 32'(res_xI2), 32'(e3));
                chk("res_xQ2", 32'(res_xQ2), 32'(e4));
            end
            chk("all_done", 32'(all_done), 32'(e_ad));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("timeout_err", 32'(timeout_err), 32'(e_te));

            // Inputs for this cycle.
            xI1_in = 16'($urandom); xQ1_in = 16'($urandom);
            xI2_in = 16'($urandom); xQ2_in = 16'($urandom);
            if (d >= 0 && o == 16 + d) begin
                q_done = 1'b1;
                e1 = xI1_in; e2 = xQ1_in; e3 = xI2_in; e4 = xQ2_in;
            end
            res_ready = (d >= 0 && o >= 17 + d + r);
            if (spur && !fin) begin
                if (o >= 1 && o <= 16 && $urandom_range(0, 3) == 0) q_done = 1'b1;
                if (d >= 0 && o >= 17 + d && o <= 17 + d + r && $urandom_range(0, 3) == 0)
                    q_done = 1'b1;
                if (o >= 1 && o <= ((d >= 0) ? 16 + d : 100) && $urandom_range(0, 7) == 0)
                    run = 1'b1;
                if (o >= 1 && o <= 16 && $urandom_range(0, 2) == 0) begin
                    wr_en = 1'b1; wr_sel = 1'($urandom); wr_addr = 4'($urandom);
                    wr_r = N'($urandom); wr_i = N'($urandom);
                end
            end
            if (guard > 20000) begin
                chk("run_cycle_bound", 0, 1);
                fin = 1;
            end
        end
        run = 1'b0; q_done = 1'b0; res_ready = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 0, 19};
        tbl[1] = '{5, 0, 23};
        tbl[2] = '{5, 10, 33};
        tbl[3] = '{2, 3, 23};

        // Reset state.
        #2 rst = 1'b0;
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b1;
        step();
        chk_zero("post_reset");

        // Sequential data run, q_done 5 cycles after last H beat, ready high.
        load_seq();
        do_run(0, -1, 1'b0);
        chk("seq_start_count", 32'(starts.size()), NUM_Q);

        // Table-driven per-q wait and backpressure; periods from the table.
        do_run(1, -1, 1'b0);
        chk("tbl_start_count", 32'(starts.size()), NUM_Q);
        for (int i = 0; i + 1 < starts.size(); i++)
            chk($sformatf("tbl_period_q%0d", i), 32'(starts[i + 1] - starts[i]),
                32'(tbl[i % 4].period));

        // Random data, random delays, backpressure at q=2, spurious inputs.
        load_rand();
        do_run(2, -1, 1'b1);

        // Timeout at q=3, then the flag stays set while idle.
        do_run(0, 3, 1'b0);
        step();
        chk("timeout_sticky", 32'(timeout_err), 1);
        chk("timeout_idle_busy", 32'(busy), 0);
        chk("timeout_no_all_done", 32'(all_done), 0);

        // Next run clears timeout_err; spurious inputs again.
        load_rand();
        do_run(2, -1, 1'b1);

        // Reset during STREAM at cnt=7.
        load_seq();
        step(); run = 1'b1;
        step(); run = 1'b0;
        chk("pre_rst_start", 32'(start_new_q), 1);
        repeat (8) step();
        chk("pre_rst_H_valid", 32'(H_in_valid), 1);
        chk("pre_rst_H_r", 32'(H_in_r), 32'(h_r[7]));
        rst = 1'b0;
        #1;
        chk_zero("mid_rst");
        step();
        chk_zero("mid_rst_held");
        rst = 1'b1;
        step();
        chk("after_rst_busy", 32'(busy), 0);
        chk("after_rst_all_done", 32'(all_done), 0);
        do_run(0, -1, 1'b0);
        chk("after_rst_start_count", 32'(starts.size()), NUM_Q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
